// File: rtl/uc_multicycle_fsm_if.sv
// Control-unit bus for the multicycle MIPS datapath: instruction fields and
// status coming in, control strobes and mux selects going out.
interface uc_multicycle_fsm_if #(
    parameter int ALUC_W = 3
);
    logic [5:0]        Op;
    logic [5:0]        Funct;
    logic              Zero;
    logic              MemReady;

    logic              PCEn;
    logic              PCWrite;
    logic              BranchEq;
    logic              BranchNeq;
    logic              IorD;
    logic              MemWrite;
    logic              IRWrite;
    logic              RegDst;
    logic              MemtoReg;
    logic              RegWrite;
    logic              ALUSrcA;
    logic              ZeroExt;
    logic [1:0]        ALUSrcB;
    logic [1:0]        PCSrc;
    logic [ALUC_W-1:0] ALUControl;
    logic [3:0]        State;
    logic              Illegal;

    // Control unit side: drives every control output.
    modport master (
        input  Op, Funct, Zero, MemReady,
        output PCEn, PCWrite, BranchEq, BranchNeq, IorD, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ZeroExt, ALUSrcB, PCSrc,
               ALUControl, State, Illegal
    );

    // Datapath side: supplies instruction fields and status.
    modport slave (
        output Op, Funct, Zero, MemReady,
        input  PCEn, PCWrite, BranchEq, BranchNeq, IorD, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ZeroExt, ALUSrcB, PCSrc,
               ALUControl, State, Illegal
    );
endinterface

// File: rtl/uc_multicycle_fsm.sv
// Multicycle MIPS control unit: one state register, everything else decoded
// combinationally from the state, Op/Funct and the memory ready handshake.
module uc_multicycle_fsm #(
    parameter int ALUC_W      = 3,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            CLR,
    uc_multicycle_fsm_if.master bus
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_IMMEX   = 4'd8;
    localparam logic [3:0] S_IMMWB   = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       mem_ready;
    logic       rtype_ok;
    logic [2:0] rtype_alu;
    logic [2:0] alu3;
    logic       pc_write, branch_eq, branch_ne, mem_write, ir_write, reg_write;
    logic       iord, reg_dst, mem_to_reg, src_a, zero_ext, illegal;
    logic [1:0] src_b, pc_src;

    // With wait states disabled the memory is assumed to answer every cycle.
    assign mem_ready = MEM_WAIT_EN ? bus.MemReady : 1'b1;

    // State register; reset returns straight to FETCH.
    always_ff @(posedge CLK or negedge CLR) begin
        // NOTE: state updates use non-blocking assignment; the combinational blocks below use blocking.
        if (!CLR) state <= S_FETCH;
        else      state <= next_state;
    end

    // R-type Funct decode: ALU operation and whether the Funct is supported.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        rtype_alu = ALU_ADD;
        rtype_ok  = 1'b1;
        case (bus.Funct)
            FN_ADD:  rtype_alu = ALU_ADD;
            FN_SUB:  rtype_alu = ALU_SUB;
            FN_AND:  rtype_alu = ALU_AND;
            FN_OR:   rtype_alu = ALU_OR;
            FN_NOR:  rtype_alu = ALU_NOR;
            FN_SLT:  rtype_alu = ALU_SLT;
            default: rtype_ok  = 1'b0;
        endcase
    end

    // Next state and per-state control outputs.
    always_comb begin
        next_state = S_FETCH;
        pc_write   = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        src_a      = 1'b0;
        zero_ext   = 1'b0;
        illegal    = 1'b0;
        src_b      = 2'b00;
        pc_src     = 2'b00;
        alu3       = ALU_ADD;
        case (state)
            S_FETCH: begin
                src_b      = 2'b01;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is computed here into ALUOut.
                src_b = 2'b11;
                case (bus.Op)
                    OP_LW, OP_SW:                     next_state = S_MEMADR;
                    OP_RTYPE: begin
                        if (rtype_ok) next_state = S_RTYPEEX;
                        else          illegal    = 1'b1;
                    end
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: next_state = S_IMMEX;
                    OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
                    OP_J:                             next_state = S_JUMP;
                    default:                          illegal    = 1'b1;
                endcase
            end
            S_MEMADR: begin
                src_a      = 1'b1;
                src_b      = 2'b10;
                next_state = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                // Write strobe is held for the whole wait.
                iord       = 1'b1;
                mem_write  = 1'b1;
                next_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                src_a      = 1'b1;
                alu3       = rtype_alu;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_IMMEX: begin
                src_a = 1'b1;
                src_b = 2'b10;
                case (bus.Op)
                    OP_SLTI: alu3 = ALU_SLT;
                    OP_ANDI: begin alu3 = ALU_AND; zero_ext = 1'b1; end
                    OP_ORI:  begin alu3 = ALU_OR;  zero_ext = 1'b1; end
                    default: alu3 = ALU_ADD;
                endcase
                next_state = S_IMMWB;
            end
            S_IMMWB: reg_write = 1'b1;
            S_BRANCH: begin
                src_a     = 1'b1;
                alu3      = ALU_SUB;
                pc_src    = 2'b01;
                branch_eq = (bus.Op == OP_BEQ);
                branch_ne = (bus.Op == OP_BNE);
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Write strobes are suppressed for as long as reset is held.
    assign bus.PCWrite    = pc_write  & CLR;
    assign bus.BranchEq   = branch_eq & CLR;
    assign bus.BranchNeq  = branch_ne & CLR;
    assign bus.MemWrite   = mem_write & CLR;
    assign bus.IRWrite    = ir_write  & CLR;
    assign bus.RegWrite   = reg_write & CLR;
    assign bus.PCEn       = CLR & (pc_write | (branch_eq & bus.Zero) | (branch_ne & ~bus.Zero));
    assign bus.IorD       = iord;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.ALUSrcA    = src_a;
    assign bus.ZeroExt    = zero_ext;
    assign bus.ALUSrcB    = src_b;
    assign bus.PCSrc      = pc_src;
    assign bus.ALUControl = ALUC_W'(alu3);
    assign bus.State      = state;
    assign bus.Illegal    = illegal;
endmodule
